// File: rtl/gpio_config_serializer.sv
// Transmit end of the GPIO configuration shift chain. Fetches one word per pad, highest index first,
// and shifts it MSB first on serial_clock/serial_data. It then strobes serial_load so every block latches.
module gpio_config_serializer #(
  parameter int NUM_IO    = 38,
  parameter int CFG_WIDTH = 10,
  parameter int CLK_DIV   = 4,
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1,
  localparam int DW = $clog2(CLK_DIV + 1),
  localparam int BW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        cfg_addr,
  input  logic [CFG_WIDTH-1:0] cfg_data,
  output logic                 serial_clock,
  output logic                 serial_data,
  output logic                 serial_load
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t               r_state;
  logic [DW-1:0]        r_div_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [CFG_WIDTH-1:0] r_shift;
  logic [AW-1:0]        r_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_sclk;
  logic                 r_sdata;
  logic                 r_sload;

  state_t               w_state_next;
  logic [DW-1:0]        w_div_next;
  logic [BW-1:0]        w_bit_next;
  logic [CFG_WIDTH-1:0] w_shift_next;
  logic [AW-1:0]        w_addr_next;
  logic                 w_phase_end;
  logic                 w_sdata_next;

  always_comb begin
    w_phase_end  = (r_div_cnt == DW'(CLK_DIV - 1));
    w_state_next = r_state;
    w_div_next   = r_div_cnt + DW'(1);
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_addr_next  = r_addr;

    case (r_state)
      ST_IDLE: begin
        w_div_next = '0;
        if (start) begin
          w_state_next = ST_FETCH;
          w_addr_next  = AW'(NUM_IO - 1);
        end
      end
      // The divider counter doubles as the two-cycle fetch timer; cfg_data is valid in the 2nd cycle.
      ST_FETCH: begin
        if (r_div_cnt == DW'(1)) begin
          w_state_next = ST_SHIFT_LO;
          w_div_next   = '0;
          w_shift_next = cfg_data;
          w_bit_next   = BW'(CFG_WIDTH - 1);
        end
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) begin
          w_state_next = ST_SHIFT_HI;
          w_div_next   = '0;
        end
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          w_div_next   = '0;
          w_shift_next = r_shift << 1;
          if (r_bit_cnt != '0) begin
            w_bit_next   = r_bit_cnt - BW'(1);
            w_state_next = ST_SHIFT_LO;
          end else if (r_addr != '0) begin
            w_addr_next  = r_addr - AW'(1);
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (w_phase_end) begin
          w_state_next = ST_DONE;
          w_div_next   = '0;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_div_next   = '0;
        w_addr_next  = AW'(NUM_IO - 1);
      end
      default: begin
        w_state_next = ST_IDLE;
        w_div_next   = '0;
      end
    endcase

    // Outputs are registered from the next state so each one is valid on the first cycle of its phase.
    case (w_state_next)
      ST_SHIFT_LO: w_sdata_next = w_shift_next[CFG_WIDTH-1];
      ST_SHIFT_HI: w_sdata_next = r_sdata;
      default:     w_sdata_next = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= AW'(NUM_IO - 1);
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdata   <= 1'b0;
      r_sload   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_div_cnt <= w_div_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_addr    <= w_addr_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= (w_state_next == ST_DONE);
      r_sclk    <= (w_state_next == ST_SHIFT_HI);
      r_sdata   <= w_sdata_next;
      r_sload   <= (w_state_next == ST_LOAD);
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign cfg_addr     = r_addr;
  assign serial_clock = r_sclk;
  assign serial_data  = r_sdata;
  assign serial_load  = r_sload;

endmodule

// File: tb/tb_gpio_config_serializer.sv
// Directed bench for gpio_config_serializer: two 2-pad chains (divider 1 and 4) and a 38-pad chain
// that feeds a behavioural receiver chain.
module tb_gpio_config_serializer;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_v;
  always #5 clk = ~clk;

  logic       a_busy, a_done, a_sc, a_sd, a_sl;
  logic [0:0] a_addr;
  logic [9:0] a_cfg;
  logic       b_busy, b_done, b_sc, b_sd, b_sl;
  logic [0:0] b_addr;
  logic [9:0] b_cfg;
  logic       c_busy, c_done, c_sc, c_sd, c_sl;
  logic [5:0] c_addr;
  logic [9:0] c_cfg;

  logic [9:0] store_a [2];
  logic [9:0] store_b [2];
  logic [9:0] store_c [38];

  // Configuration store with one cycle of read latency.
  always @(posedge clk) begin
    a_cfg <= store_a[a_addr];
    b_cfg <= store_b[b_addr];
    c_cfg <= store_c[c_addr];
  end

  gpio_config_serializer #(.NUM_IO(2), .CFG_WIDTH(10), .CLK_DIV(1)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[0]), .busy(a_busy), .done(a_done),
    .cfg_addr(a_addr), .cfg_data(a_cfg), .serial_clock(a_sc), .serial_data(a_sd), .serial_load(a_sl));

  gpio_config_serializer #(.NUM_IO(2), .CFG_WIDTH(10), .CLK_DIV(4)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[1]), .busy(b_busy), .done(b_done),
    .cfg_addr(b_addr), .cfg_data(b_cfg), .serial_clock(b_sc), .serial_data(b_sd), .serial_load(b_sl));

  gpio_config_serializer #(.NUM_IO(38), .CFG_WIDTH(10), .CLK_DIV(1)) u_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_v[2]), .busy(c_busy), .done(c_done),
    .cfg_addr(c_addr), .cfg_data(c_cfg), .serial_clock(c_sc), .serial_data(c_sd), .serial_load(c_sl));

  // Behavioural 38-stage receiver chain: shift on the rising serial_clock, latch on serial_load.
  logic [9:0] rx_sr  [38];
  logic [9:0] rx_lat [38];
  always @(posedge c_sc) begin
    rx_sr[0] <= {rx_sr[0][8:0], c_sd};
    for (int i = 1; i < 38; i++) rx_sr[i] <= {rx_sr[i][8:0], rx_sr[i-1][9]};
  end
  always @(posedge clk) begin
    if (c_sl) begin
      for (int i = 0; i < 38; i++) rx_lat[i] <= rx_sr[i];
    end
  end

  int         mon_sel;
  logic       m_busy, m_done, m_sc, m_sd, m_sl;
  logic [5:0] m_addr;
  always_comb begin
    case (mon_sel)
      1: begin
        m_busy = b_busy; m_done = b_done; m_sc = b_sc; m_sd = b_sd; m_sl = b_sl; m_addr = {5'd0, b_addr};
      end
      2: begin
        m_busy = c_busy; m_done = c_done; m_sc = c_sc; m_sd = c_sd; m_sl = c_sl; m_addr = c_addr;
      end
      default: begin
        m_busy = a_busy; m_done = a_done; m_sc = a_sc; m_sd = a_sd; m_sl = a_sl; m_addr = {5'd0, a_addr};
      end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int div_of(input int sel);
    return (sel == 1) ? 4 : 1;
  endfunction

  // Results of the most recent monitored transmission.
  int          cyc, done_cyc, done_cnt, edges, load_cyc, load_at, unstable, hi_bad, restarted;
  int          post_addr, addr_pack;
  logic [63:0] cap;

  // Called at a negedge; start is high across exactly one rising clock edge.
  task automatic pulse_start(input int sel);
    mon_sel      = sel;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Samples the selected DUT on each falling edge, beginning with the first busy cycle.
  task automatic monitor(input int sel, input int budget, input int extra, input bit stray);
    int   d, f2, post, hi_len;
    logic prev_sc, prev_sd;
    d = div_of(sel);
    f2 = 3 + 20 * d;
    cyc = 0; done_cyc = 0; done_cnt = 0; edges = 0; load_cyc = 0; load_at = -1;
    unstable = 0; hi_bad = 0; restarted = 0; post_addr = -1; addr_pack = 0; cap = '0;
    post = 0; hi_len = 0; prev_sc = 1'b0; prev_sd = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (m_busy) cyc++;
      if (m_busy && (cyc == 1 || cyc == 2 || cyc == f2 || cyc == f2 + 1))
        addr_pack = (addr_pack << 4) | int'(m_addr);
      if (m_sc && !prev_sc) begin
        cap = {cap[62:0], m_sd};
        edges++;
        if (m_sd != prev_sd) unstable++;
      end else if (m_sc && prev_sc && m_sd != prev_sd) begin
        unstable++;
      end
      if (m_sc) hi_len++;
      else if (prev_sc) begin
        if (hi_len != d) hi_bad++;
        hi_len = 0;
      end
      if (m_sl) begin
        load_cyc++;
        if (load_at < 0) load_at = edges;
      end
      if (m_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      prev_sc = m_sc;
      prev_sd = m_sd;
      if (stray && done_cnt == 0 && $urandom_range(0, 3) == 0) start_v[sel] = 1'b1;
      else start_v[sel] = 1'b0;
      if (done_cnt > 0) begin
        if (post > 0 && m_busy) restarted = 1;
        post_addr = int'(m_addr);
        if (post >= extra) break;
        post++;
      end
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
  endtask

  typedef struct {
    int         sel;
    logic [9:0] w1;
    logic [9:0] w0;
    logic [19:0] exp_bits;
    int         exp_done;
    int         exp_load;
    bit         stray;
  } vec_t;

  vec_t vecs [6];

  task automatic check_pair_run(input string tag, input int exp_bits, input int exp_done, input int exp_load);
    check({tag, "_bits"}, int'(cap[19:0]), exp_bits);
    check({tag, "_edges"}, edges, 20);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_load_cycles"}, load_cyc, exp_load);
    check({tag, "_load_after_edges"}, load_at, 20);
    check({tag, "_data_stable"}, unstable, 0);
    check({tag, "_hi_period"}, hi_bad, 0);
    check({tag, "_addr_seq"}, addr_pack, 32'h1100);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_no_restart"}, restarted, 0);
    check({tag, "_idle_addr"}, post_addr, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, sl_seen, k;
    vecs[0] = '{0, 10'h209, 10'h003, 20'h82403, 46,  1, 1'b0};
    vecs[1] = '{1, 10'h209, 10'h003, 20'h82403, 169, 4, 1'b0};
    vecs[2] = '{0, 10'h3FF, 10'h000, 20'hFFC00, 46,  1, 1'b0};
    vecs[3] = '{1, 10'h155, 10'h2AA, 20'h556AA, 169, 4, 1'b0};
    vecs[4] = '{0, 10'h209, 10'h003, 20'h82403, 46,  1, 1'b1};
    vecs[5] = '{1, 10'h001, 10'h200, 20'h00600, 169, 4, 1'b1};

    rst = 1'b1;
    start_v = '0;
    mon_sel = 0;
    store_a[0] = '0; store_a[1] = '0; store_b[0] = '0; store_b[1] = '0;
    for (int i = 0; i < 38; i++) store_c[i] = 10'(1 + $urandom_range(0, 1022));
    repeat (3) @(negedge clk);

    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_addr_a", int'(a_addr), 1);
    check("rst_addr_c", int'(c_addr), 37);
    check("rst_sclk", int'(a_sc), 0);
    check("rst_sdata", int'(a_sd), 0);
    check("rst_sload", int'(a_sl), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].sel == 0) begin store_a[1] = vecs[v].w1; store_a[0] = vecs[v].w0; end
      else begin store_b[1] = vecs[v].w1; store_b[0] = vecs[v].w0; end
      @(negedge clk);
      pulse_start(vecs[v].sel);
      monitor(vecs[v].sel, 400, 3, vecs[v].stray);
      check_pair_run($sformatf("v%0d", v), int'(vecs[v].exp_bits), vecs[v].exp_done, vecs[v].exp_load);
      $display("[TB] vec %0d sel %0d stray %0d: bits %05h edges %0d done@%0d", v, vecs[v].sel,
               vecs[v].stray, cap[19:0], edges, done_cyc);
    end

    // Back-to-back: second start lands in the IDLE cycle right after done.
    store_a[1] = 10'h209; store_a[0] = 10'h003;
    @(negedge clk);
    pulse_start(0);
    monitor(0, 400, 1, 1'b0);
    check_pair_run("b2b_first", 32'h82403, 46, 1);
    pulse_start(0);
    monitor(0, 400, 3, 1'b0);
    check_pair_run("b2b_second", 32'h82403, 46, 1);
    $display("[TB] back-to-back: bits %05h done@%0d addr_seq %04h", cap[19:0], done_cyc, addr_pack);

    // Reset during the first SHIFT_HI of word 1 on the divide-by-4 chain.
    store_b[1] = 10'h209; store_b[0] = 10'h003;
    @(negedge clk);
    pulse_start(1);
    sl_seen = 0;
    k = 0;
    while (!m_sc && k < 50) begin
      if (m_sl) sl_seen++;
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached_hi", int'(m_sc), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", int'(m_busy), 0);
    check("rst_mid_done", int'(m_done), 0);
    check("rst_mid_addr", int'(m_addr), 1);
    check("rst_mid_sclk", int'(m_sc), 0);
    check("rst_mid_sdata", int'(m_sd), 0);
    check("rst_mid_sload", int'(m_sl), 0);
    bad = 0;
    repeat (30) begin
      if (m_sl) sl_seen++;
      if (m_busy) bad++;
      @(negedge clk);
    end
    check("rst_mid_no_load", sl_seen, 0);
    check("rst_mid_stays_idle", bad, 0);
    pulse_start(1);
    monitor(1, 400, 3, 1'b0);
    check_pair_run("rst_rerun", 32'h82403, 169, 4);
    $display("[TB] reset mid-shift then rerun: bits %05h done@%0d", cap[19:0], done_cyc);

    // Full 38-pad chain into the receiver model.
    @(negedge clk);
    pulse_start(2);
    monitor(2, 1000, 2, 1'b0);
    check("c38_done_cycle", done_cyc, 838);
    check("c38_edges", edges, 380);
    check("c38_load_cycles", load_cyc, 1);
    check("c38_data_stable", unstable, 0);
    bad = 0;
    for (int i = 0; i < 38; i++) begin
      check($sformatf("c38_word%0d", i), int'(rx_lat[i]), int'(store_c[i]));
    end
    $display("[TB] 38-pad chain: edges %0d done@%0d word0 %03h word37 %03h", edges, done_cyc,
             rx_lat[0], rx_lat[37]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_config_serializer.md
Name: gpio_config_serializer

Overview:
- Transmit end of the GPIO configuration shift chain.
- On request, it reads one configuration word per GPIO from the housekeeping configuration store. The store's words are initialised from each pad's gpio_defaults value.
- It shifts the words serially, MSB first, down the daisy-chained GPIO control blocks, then pulses serial_load so every block latches its word in parallel.
- It drives the serial_clock / serial_data / serial_load bus that the per-pad control blocks receive.

Parameters:
- NUM_IO, 38: number of GPIO control blocks in the chain.
- CFG_WIDTH, 10: bits per configuration word; matches gpio_defaults width.
- CLK_DIV, 4: wb_clk_i cycles per serial_clock half-period; legal range is 1 or more.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to (re)transmit the full chain; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the chain is loaded.
- cfg_addr  out  $clog2(NUM_IO)  index of the configuration word being fetched.
- cfg_data  in  CFG_WIDTH  word at cfg_addr; valid one cycle after cfg_addr changes.
- serial_clock  out  1  chain shift clock; receivers sample on its rising edge.
- serial_data  out  1  chain data; changes only while serial_clock is low.
- serial_load  out  1  parallel-latch strobe to all control blocks.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: busy=0, done=0, cfg_addr=NUM_IO-1, serial_clock=0, serial_data=0, serial_load=0, FSM in IDLE, shift register and counters zeroed.
- Reset mid-operation: all outputs return to their reset values on the next edge. There is no partial load pulse; the chain content is undefined until the next full transmission.
- FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: if start=1, go to FETCH with cfg_addr=NUM_IO-1. busy goes high in the FETCH cycles. start in any other state is ignored; there is no queuing.
- FETCH: lasts exactly 2 cycles with cfg_addr held stable. At the end of the 2nd cycle, cfg_data is captured into the CFG_WIDTH shift register and the bit counter is set to CFG_WIDTH-1. Then go to SHIFT_LO.
- SHIFT_LO: lasts CLK_DIV cycles. serial_clock=0 and serial_data = shift register MSB, updated on entry. Then go to SHIFT_HI.
- SHIFT_HI: lasts CLK_DIV cycles. serial_clock=1 and serial_data is held. On exit the shift register shifts left by one.
  - If bit counter ≠ 0: decrement the bit counter and go to SHIFT_LO.
  - Else if cfg_addr ≠ 0: decrement cfg_addr and go to FETCH.
  - Else go to LOAD.
- Word order: the highest index is sent first, so word 0 ends nearest the serializer after NUM_IO*CFG_WIDTH rising edges.
- serial_clock is low throughout FETCH, LOAD, DONE and IDLE.
- LOAD: lasts CLK_DIV cycles with serial_load=1, serial_clock=0 and serial_data=0.
- DONE: lasts 1 cycle with done=1 and busy still 1. Next cycle: IDLE, busy=0, cfg_addr=NUM_IO-1.
- Total cycles from first busy cycle to the done pulse, inclusive: NUM_IO*(2 + 2*CLK_DIV*CFG_WIDTH) + CLK_DIV + 1.
- Exact rising-edge count per transmission: NUM_IO*CFG_WIDTH.
- Counters: the divider counter is $clog2(CLK_DIV+1) bits wide and wraps to 0 at each phase change. The bit counter is $clog2(CFG_WIDTH) bits wide.
- NUM_IO=1 is legal: the single word is sent, then LOAD.
- All outputs are registered; no combinational path from start or cfg_data to any output.

Test Plan:
1. NUM_IO=2, CFG_WIDTH=10, CLK_DIV=1, store words {1: 0x209, 0: 0x003}, pulse start.
   - Required: 20 rising edges of serial_clock; serial_data sequence = 10'b1000001001 then 10'b0000000011.
   - Required: serial_load high for 1 cycle after the last edge; done 46 cycles after the first busy cycle.
2. Same configuration with CLK_DIV=4.
   - Required: each serial_clock half-period is 4 cycles; serial_data is stable across every rising edge.
   - Required: done arrives at cycle 2*(2+80)+4+1 = 169.
3. Assert start again in random cycles during busy.
   - Required: no restart; exactly one done; bit sequence unchanged.
4. Assert wb_rst_i for 1 cycle mid-SHIFT_HI of word 1.
   - Required: the next cycle shows all reset values; serial_load never pulses; a new start produces a full, correct 20-bit transmission.
5. Back-to-back: start in the cycle after done (IDLE).
   - Required: accepted; second transmission identical; cfg_addr sequence 1,1,0,0 per run.
6. Model check with NUM_IO=38, CLK_DIV=1, random words, behavioural 38-stage receiver chain.
   - Required: latched words equal the store contents for every index after done.
